sipo_rx: RTL and testbench

//  Serial-in/parallel-out receiver; the stage directly downstream of the PISO serializer.

---
 rtl/sipo_pkg.sv | 27 ++
 rtl/sipo_out_slot.sv | 78 +++++++
 rtl/sipo_rx.sv | 136 +++++++++++++
 tb/tb_sipo_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
// Optional feature macro: SIPO_PARITY_EN (adds a trailing even-parity bit per frame).
package sipo_pkg;

    // Default parallel word width; matches the upstream serializer.
    localparam int SIPO_WIDTH = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } sipo_state_t;

    typedef enum bit {
        MSB_FIRST,
        LSB_FIRST
    } sipo_order_t;

    // Number of serial bits that make up one frame.
    function automatic int frame_len(input int width);
`ifdef SIPO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// One-entry output holding register with valid/ready handshake.
// A load while the slot is full and not draining is dropped and flagged (sticky).
// Optional feature macro: SIPO_PARITY_EN (carries a parity-error flag with the word).
module sipo_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
`ifdef SIPO_PARITY_EN
    input  logic             perr_i,
    output logic             perr_o,
`endif
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
`ifdef SIPO_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // Next-state: drain on transfer, load when empty or draining, else drop and flag.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
`ifdef SIPO_PARITY_EN
        perr_d  = perr_q;
`endif
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            if (!valid_q || ready_i) begin
                data_d  = data_i;
                valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                perr_d  = perr_i;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
`ifdef SIPO_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;
`ifdef SIPO_PARITY_EN
    assign perr_o     = perr_q;
`endif

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: collects qualified bits MSB- or LSB-first into a
// WIDTH-bit word and hands it to a one-entry valid/ready output slot one clock after
// the last bit of the frame.
// Optional feature macro: SIPO_PARITY_EN (frame gains a trailing even-parity bit and a
// parity_err output registered alongside sipo_out).
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sipo_in,
    input  logic             sipo_valid,
    input  logic             LSB,
    output logic [WIDTH-1:0] sipo_out,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SIPO_PARITY_EN
    output logic             overflow,
    output logic             parity_err
`else
    output logic             overflow
`endif
);

    localparam int               FRAME     = frame_len(WIDTH);
    localparam int               CNT_W     = $clog2(FRAME + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(WIDTH);

    sipo_state_t      state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    sipo_order_t      ord_q, ord_d;
    sipo_order_t      ord_eff;
    logic             done_q, done_d;
`ifdef SIPO_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // Frame FSM, bit counter and shift register next-state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        ord_d     = ord_q;
        done_d    = 1'b0;
`ifdef SIPO_PARITY_EN
        perr_d    = perr_q;
`endif
        // The first bit of a frame already uses the freshly sampled order.
        ord_eff   = (state_q == IDLE) ? sipo_order_t'(LSB) : ord_q;

        case (state_q)
            IDLE: begin
                if (sipo_valid) begin
                    ord_d     = sipo_order_t'(LSB);
                    bit_cnt_d = CNT_W'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sipo_valid) begin
                    if (bit_cnt_q == LAST_IDX) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                        done_d    = 1'b1;
`ifdef SIPO_PARITY_EN
                        // Data is complete in sh_q; sipo_in is the parity bit.
                        perr_d    = ^{sh_q, sipo_in};
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Only data bits enter the shift register; a trailing parity bit does not.
        if (sipo_valid && (bit_cnt_q < DATA_BITS)) begin
            if (ord_eff == LSB_FIRST) begin
                sh_d = {sipo_in, sh_q[WIDTH-1:1]};
            end else begin
                sh_d = {sh_q[WIDTH-2:0], sipo_in};
            end
        end
    end

    // Receiver state registers with synchronous reset; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            ord_q     <= MSB_FIRST;
            done_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            ord_q     <= ord_d;
            done_q    <= done_d;
`ifdef SIPO_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // done_q marks the cycle after the last bit, when sh_q holds the finished word.
    // A new frame may start shifting on that same edge; the slot samples the old value.
    sipo_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load_i     (done_q),
        .data_i     (sh_q),
`ifdef SIPO_PARITY_EN
        .perr_i     (perr_q),
        .perr_o     (parity_err),
`endif
        .ready_i    (out_ready),
        .data_o     (sipo_out),
        .valid_o    (out_valid),
        .overflow_o (overflow)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Directed self-checking bench for sipo_rx (WIDTH = 8).
// Build with +define+SIPO_PARITY_EN to also exercise the parity frame format.
module tb_sipo_rx;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk;
    logic         reset;
    logic         sipo_in;
    logic         sipo_valid;
    logic         LSB;
    logic [W-1:0] sipo_out;
    logic         out_valid;
    logic         out_ready;
    logic         overflow;
    logic         parity_err;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] got_q[$];

    sipo_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sipo_in    (sipo_in),
        .sipo_valid (sipo_valid),
        .LSB        (LSB),
        .sipo_out   (sipo_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SIPO_PARITY_EN
        .overflow   (overflow),
        .parity_err (parity_err)
`else
        .overflow   (overflow)
`endif
    );

`ifndef SIPO_PARITY_EN
    assign parity_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word actually transferred to the consumer.
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) got_q.push_back(sipo_out);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
            $error("check %s failed", tag);
        end
    endtask

    // Drive one frame, one bit per negedge; optional one-cycle gaps and mid-frame LSB flips.
    task automatic send_word(input logic [W-1:0] w, input logic lsb, input logic pbit,
                             input bit gap, input bit flip, input bit release_after);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (gap && i > 0) begin
                sipo_valid = 1'b0;
                @(negedge clk);
            end
            sipo_valid = 1'b1;
            LSB        = (flip && i > 0) ? ~lsb : lsb;
            if (i < W) sipo_in = lsb ? w[i] : w[W-1-i];
            else       sipo_in = pbit;
        end
        if (release_after) begin
            @(negedge clk);
            sipo_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for a word, check it, then let one edge pass for the transfer.
    task automatic expect_word(input string tag, input logic [W-1:0] w, input logic perr);
        int n = 0;
        while (!out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(sipo_out), 32'(w));
`ifdef SIPO_PARITY_EN
        check({tag, "_perr"}, 32'(parity_err), 32'(perr));
`else
        if (perr) $display("note: parity expectation ignored in this build");
`endif
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; sipo_in = 1'b0; sipo_valid = 1'b0; LSB = 1'b0; out_ready = 1'b0;

        // 1. reset state
        repeat (2) @(negedge clk);
        check("rst_sipo_out", 32'(sipo_out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        reset = 1'b0;

        // 2. MSB-first A5 with exact one-clock latency
        out_ready = 1'b1;
        send_word(8'hA5, 1'b0, 1'b0, 0, 0, 1);
        check("t2_not_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data", 32'(sipo_out), 32'hA5);
        @(negedge clk);
        check("t2_consumed", 32'(out_valid), 32'd0);

        // 3. LSB-first, gapped input, and LSB toggling mid-frame
        send_word(8'h3C, 1'b1, 1'b0, 0, 0, 1);
        expect_word("t3_lsb", 8'h3C, 1'b0);
        send_word(8'hF0, 1'b0, 1'b0, 1, 0, 1);
        expect_word("t3_gap", 8'hF0, 1'b0);
        send_word(8'h3C, 1'b1, 1'b0, 0, 1, 1);
        expect_word("t3_flip", 8'h3C, 1'b0);

        // back-to-back frames with no idle cycle
        got_q.delete();
        send_word(8'h5A, 1'b0, 1'b0, 0, 0, 0);
        send_word(8'hC3, 1'b0, 1'b0, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("b2b_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("b2b_first", 32'(got_q[0]), 32'h5A);
            check("b2b_second", 32'(got_q[1]), 32'hC3);
        end

        // slot draining exactly at completion: new word loads, no overflow
        got_q.delete();
        out_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b0, 0, 0, 1);
        @(negedge clk);
        check("drain_hold", 32'(sipo_out), 32'h11);
        send_word(8'h44, 1'b0, 1'b0, 0, 0, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_data", 32'(sipo_out), 32'h44);
        check("drain_valid", 32'(out_valid), 32'd1);
        check("drain_no_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        check("drain_count", 32'(got_q.size()), 32'd2);

        // 4. slot full at completion: second word dropped, overflow sticky
        got_q.delete();
        out_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b0, 0, 0, 1);
        @(negedge clk);
        check("t4_first_valid", 32'(out_valid), 32'd1);
        check("t4_first_data", 32'(sipo_out), 32'h11);
        check("t4_no_ovf_yet", 32'(overflow), 32'd0);
        send_word(8'h22, 1'b0, 1'b0, 0, 0, 1);
        @(negedge clk);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_kept", 32'(sipo_out), 32'h11);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_cleared", 32'(out_valid), 32'd0);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        check("t4_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check("t4_xfer", 32'(got_q[0]), 32'h11);

        // 5. reset mid-frame discards the partial frame
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sipo_valid = 1'b1;
            LSB        = 1'b0;
            sipo_in    = 1'b1;
        end
        @(negedge clk);
        sipo_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_ovf_reset", 32'(overflow), 32'd0);
        got_q.delete();
        send_word(8'h81, 1'b0, 1'b0, 0, 0, 1);
        expect_word("t5", 8'h81, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_count", 32'(got_q.size()), 32'd1);

`ifdef SIPO_PARITY_EN
        // 6. parity: A5 has four ones, so pbit=0 is good and pbit=1 is an error
        send_word(8'hA5, 1'b0, 1'b0, 0, 0, 1);
        expect_word("t6_ok", 8'hA5, 1'b0);
        send_word(8'hA5, 1'b0, 1'b1, 0, 0, 1);
        expect_word("t6_err", 8'hA5, 1'b1);
        send_word(8'h07, 1'b1, 1'b1, 0, 0, 1);
        expect_word("t6_odd_ok", 8'h07, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
